// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM state encoding and port indices for the RAM arbiter.
package ram_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_e;
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: two requester ports plus RAM pin bundle for ram_arbiter.
interface ram_arbiter_if #(parameter int ADDR_W = 9, parameter int DATA_W = 8);
    logic              p0_req, p0_we, p0_ack;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata, p0_rdata;
    logic              p1_req, p1_we, p1_ack;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata, p1_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in, ram_data_out;
    logic              ram_write_rq, ram_output_en, busy;
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, ram_data_out,
        output p0_ack, p0_rdata, p1_ack, p1_rdata, ram_addr, ram_data_in, ram_write_rq,
               ram_output_en, busy
    );
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p1_req, p1_we, p1_addr, p1_wdata, ram_data_out,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata, ram_addr, ram_data_in, ram_write_rq,
               ram_output_en, busy
    );
endinterface

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select; round robin, or fixed p0 priority
// when RAM_ARB_FIXED_PRIO_EN is defined.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_grant_i,
    input  logic [1:0] mask_i,
    output logic       valid_o,
    output logic       win_o
);
`ifdef RAM_ARB_FIXED_PRIO_EN
    assign win_o = req0_i ? P0 : (req1_i ? P1 : last_grant_i);
`else
    assign win_o = (req0_i && req1_i) ? ~last_grant_i : (req1_i ? P1 : P0);
`endif
    // A masked winner (port just acked) means nobody is eligible this cycle
    assign valid_o = (req0_i || req1_i) && !mask_i[win_o];
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises two request ports onto a single-port registered RAM.
// Policy: round robin, or fixed p0 priority with RAM_ARB_FIXED_PRIO_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input logic           clk,
    input logic           reset,
    ram_arbiter_if.slave  bus
);
    state_e            state_q, state_d;
    logic              lg_q, lg_d, port_q, port_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              valid, win, take;
    logic [1:0]        mask;
    assign mask = (state_q == DONE) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    ram_arb_pick u_pick (
        .req0_i       (bus.p0_req),
        .req1_i       (bus.p1_req),
        .last_grant_i (lg_q),
        .mask_i       (mask),
        .valid_o      (valid),
        .win_o        (win)
    );
    assign take = (state_q != ISSUE) && valid;
    always_comb begin
        state_d = (state_q == ISSUE) ? DONE : (valid ? ISSUE : IDLE);
        lg_d    = take ? win : lg_q;
        port_d  = take ? win : port_q;
        we_d    = take ? (win ? bus.p1_we : bus.p0_we) : we_q;
        addr_d  = take ? (win ? bus.p1_addr : bus.p0_addr) : addr_q;
        wdata_d = take ? (win ? bus.p1_wdata : bus.p0_wdata) : wdata_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lg_q    <= P1;
            port_q  <= P0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            lg_q    <= lg_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
    // Write strobe decodes straight from state so an async reset kills it at once
    assign bus.ram_write_rq  = (state_q == ISSUE) && we_q;
    assign bus.ram_output_en = (state_q == ISSUE);
    assign bus.ram_addr      = addr_q;
    assign bus.ram_data_in   = wdata_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.p0_ack        = (state_q == DONE) && (port_q == P0);
    assign bus.p1_ack        = (state_q == DONE) && (port_q == P1);
    assign bus.p0_rdata      = bus.p0_ack ? bus.ram_data_out : '0;
    assign bus.p1_rdata      = bus.p1_ack ? bus.ram_data_out : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed table, corner sequences and random traffic against a
// memory scoreboard, with a behavioural write-then-read RAM attached.
module tb_ram_arbiter;
    localparam int AW = 9;
    localparam int DW = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk)
        if (bus.ram_output_en) begin
            if (bus.ram_write_rq) begin
                ram[bus.ram_addr] <= bus.ram_data_in;
                bus.ram_data_out  <= bus.ram_data_in;
            end else bus.ram_data_out <= ram[bus.ram_addr];
        end
    typedef struct {
        bit           port;
        bit           we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl [8];
    int vecs = 0;
    int miss = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic drive(input bit p, input bit r, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        if (p) begin
            bus.p1_req = r; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
        end else begin
            bus.p0_req = r; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
        end
    endtask
    function automatic logic ack_of(input bit p);
        return p ? bus.p1_ack : bus.p0_ack;
    endfunction
    function automatic logic [DW-1:0] rdata_of(input bit p);
        return p ? bus.p1_rdata : bus.p0_rdata;
    endfunction
    // Called at a negedge with the arbiter idle; request alone, expect ack 2 cycles later
    task automatic single(input vec_t v, input string nm);
        int lat = 0;
        bit got = 0;
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (ack_of(!v.port)) chk({nm, "_other_ack"}, 1, 0);
            if (ack_of(v.port)) begin
                got = 1;
                chk({nm, "_rdata"}, rdata_of(v.port), v.exp);
                drive(v.port, 1'b0, v.we, v.addr, v.wdata);
            end
        end
        chk({nm, "_latency"}, got ? lat : 99, 2);
        @(negedge clk);
    endtask
    logic [DW-1:0] ref_mem [16];
    bit            pend [2];
    int            waitc [2];
    bit            twe [2];
    logic [AW-1:0] taddr [2];
    logic [DW-1:0] tdat [2];
    initial begin
        logic [AW-1:0] aq [$];
        int c0, c1, n, last;
        bit a0, a1;
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        tbl[0] = '{1, 1, 9'h1FF, 8'h3C, 8'h3C};
        tbl[1] = '{0, 1, 9'h005, 8'hA5, 8'hA5};
        tbl[2] = '{0, 0, 9'h005, 8'h00, 8'hA5};
        tbl[3] = '{0, 0, 9'h1FF, 8'h00, 8'h3C};
        tbl[4] = '{1, 0, 9'h005, 8'h00, 8'hA5};
        tbl[5] = '{1, 1, 9'h000, 8'hFF, 8'hFF};
        tbl[6] = '{1, 0, 9'h000, 8'h00, 8'hFF};
        tbl[7] = '{0, 1, 9'h010, 8'h77, 8'h77};
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_acks", {bus.p0_ack, bus.p1_ack}, 0);
        chk("rst_wrq", bus.ram_write_rq, 0);
        chk("rst_oen", bus.ram_output_en, 0);
        chk("rst_addr", bus.ram_addr, 0);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) single(tbl[i], $sformatf("tbl%0d", i));
        // Contended reads straight after reset: p0 first, then p1
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        drive(0, 1, 0, 9'h005, '0);
        drive(1, 1, 0, 9'h1FF, '0);
        c0 = 0; c1 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.ram_output_en) aq.push_back(bus.ram_addr);
            if (bus.p0_ack) begin c0 = c; chk("t2_rd0", bus.p0_rdata, 8'hA5); bus.p0_req = 0; end
            if (bus.p1_ack) begin c1 = c; chk("t2_rd1", bus.p1_rdata, 8'h3C); bus.p1_req = 0; end
        end
        chk("t2_p0_cycle", c0, 2);
        chk("t2_p1_cycle", c1, 4);
        chk("t2_naddr", aq.size(), 2);
        if (aq.size() == 2) begin
            chk("t2_addr0", aq[0], 9'h005);
            chk("t2_addr1", aq[1], 9'h1FF);
        end
        // Continuous contention
        drive(0, 1, 0, 9'h005, '0);
        drive(1, 1, 0, 9'h1FF, '0);
        n = 0; last = 0;
        for (int c = 1; c <= 30 && n < 8; c++) begin
            @(negedge clk);
            chk("t3_excl", bus.p0_ack & bus.p1_ack, 0);
`ifndef RAM_ARB_FIXED_PRIO_EN
            chk("t3_busy", bus.busy, 1);
`endif
            if (bus.p0_ack || bus.p1_ack) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                chk("t3_order", bus.p1_ack, 0);
`else
                chk("t3_order", bus.p1_ack, n % 2);
                if (n > 0) chk("t3_gap", c - last, 2);
`endif
                chk("t3_rdata", bus.p1_ack ? bus.p1_rdata : bus.p0_rdata,
                    bus.p1_ack ? 8'h3C : 8'hA5);
                last = c;
                n++;
            end
        end
        chk("t3_count", n, 8);
        bus.p0_req = 0;
        bus.p1_req = 0;
        @(negedge clk);
        @(negedge clk);
        // Reset during ISSUE of a write must suppress it
        drive(0, 1, 1, 9'h010, 8'h33);
        @(posedge clk);
        #1;
        chk("t5_wrq_issue", bus.ram_write_rq, 1);
        reset = 1'b1;
        #1;
        chk("t5_wrq_killed", bus.ram_write_rq, 0);
        chk("t5_busy", bus.busy, 0);
        @(negedge clk);
        bus.p0_req = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_noack", {bus.p0_ack, bus.p1_ack}, 0);
        end
        single('{0, 0, 9'h010, 8'h00, 8'h77}, "t5_read");
        // Random traffic on a fresh address window, checked against ref_mem
        for (int p = 0; p < 2; p++) pend[p] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            a0 = bus.p0_ack;
            a1 = bus.p1_ack;
            if (a0 && a1) chk("rnd_excl", 1, 0);
            for (int p = 0; p < 2; p++) begin
                if ((p ? a1 : a0) && !pend[p]) chk($sformatf("rnd_spurious%0d", p), 1, 0);
                if (pend[p]) begin
                    waitc[p]++;
                    if (p ? a1 : a0) begin
                        chk($sformatf("rnd_rdata%0d", p), rdata_of(p[0]),
                            twe[p] ? tdat[p] : ref_mem[taddr[p][3:0]]);
                        if (twe[p]) ref_mem[taddr[p][3:0]] = tdat[p];
                        pend[p] = 0;
                        drive(p[0], 0, twe[p], taddr[p], tdat[p]);
                    end else if (waitc[p] > 40) begin
                        $display("FAIL rnd_timeout%0d: waited %0d cycles, limit 40", p, waitc[p]);
                        miss++;
                        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
                        $fatal(1);
                    end
`ifndef RAM_ARB_FIXED_PRIO_EN
                    else if (waitc[p] > 5) chk($sformatf("rnd_latency%0d", p), waitc[p], 5);
`endif
                end else if (!(p ? a1 : a0) && $urandom_range(1, 0) == 1) begin
                    pend[p]  = 1;
                    waitc[p] = 0;
                    twe[p]   = 1'($urandom_range(1, 0));
                    taddr[p] = 9'h100 | 9'($urandom_range(15, 0));
                    tdat[p]  = 8'($urandom);
                    drive(p[0], 1, twe[p], taddr[p], tdat[p]);
                end
            end
        end
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
